uart_tx_fsm: RTL and testbench

//  Transmit-side frame controller: accepts one parallel word, emits a UART frame on TX_OUT,
//  one bit per CLK (CLK is the baud-rate tick domain): start(0), DATA_WIDTH data bits LSB first,

---
 rtl/uart_tx_fsm_pkg.sv | 20 ++
 rtl/uart_tx_fsm_if.sv | 28 ++
 rtl/uart_tx_fsm_serializer.sv | 45 ++++
 rtl/uart_tx_fsm.sv | 111 +++++++++++
 tb/tb_uart_tx_fsm.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fsm_pkg.sv
// rtl/uart_tx_fsm_pkg.sv - shared constants and state type for the UART transmit path
//
// Purpose: frame width, bit-counter width and the transmit FSM state encoding,
//          shared by the transmit FSM, its serializer and the host-side interface.
// Ports:   none (package).
package uart_tx_fsm_pkg;

  localparam int DATA_WIDTH = 8;
  // A 1-bit counter is still needed when the frame carries a single data bit.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fsm_if.sv
// rtl/uart_tx_fsm_if.sv - host-side handshake and serial-line bundle for uart_tx_fsm
//
// Purpose: groups the word request (P_DATA/Data_Valid/PAR_EN), the parity bit from
//          parity_calc and the transmitter status (TX_OUT/Busy).
// Modports:
//   master - host side: drives P_DATA, Data_Valid, PAR_EN, par_bit; observes TX_OUT, Busy
//   slave  - transmitter: consumes the request and par_bit; drives TX_OUT, Busy
interface uart_tx_fsm_if;
  import uart_tx_fsm_pkg::*;

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  par_bit;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, par_bit,
    input  TX_OUT, Busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, par_bit,
    output TX_OUT, Busy
  );

endinterface

// File: rtl/uart_tx_fsm_serializer.sv
// rtl/uart_tx_fsm_serializer.sv - data shift register and bit counter for the UART frame
//
// Purpose: holds the accepted word and presents it one bit at a time, LSB first.
// Ports:
//   CLK, RST   in  clock, asynchronous active-low reset
//   load       in  capture load_data (accept edge)
//   shift_en   in  advance to the next data bit
//   load_data  in  DATA_WIDTH word to send
//   ser_data   out bit that goes on the line at the next shift
//   ser_done   out the last data bit is currently on the line
module uart_tx_serializer
  import uart_tx_fsm_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  logic [DATA_WIDTH-1:0] sreg;
  logic [CNT_W-1:0]      cnt;

  // The first shift happens on the START->DATA edge and puts bit 0 on the line.
  // Loading the counter with all-ones makes that first shift wrap it to 0, so
  // during the i-th DATA cycle cnt == i.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= load_data;
      cnt  <= '1;
    end else if (shift_en) begin
      sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign ser_data = sreg[0];
  assign ser_done = (cnt == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_fsm.sv
// rtl/uart_tx_fsm.sv - UART transmit frame controller (start, data LSB first, parity, stop)
//
// Purpose: accepts one word while idle and sends start(0), DATA_WIDTH data bits LSB first,
//          an optional parity bit and stop(1), one bit per CLK. TX_OUT and Busy are flops.
// Ports:
//   CLK    in  baud-tick clock, rising edge
//   RST    in  asynchronous active-low reset; aborts a frame and idles the line high
//   tx_if  slave modport of uart_tx_fsm_if (P_DATA, Data_Valid, PAR_EN, par_bit in;
//          TX_OUT, Busy out)
module uart_tx_fsm
  import uart_tx_fsm_pkg::*;
(
  input  logic          CLK,
  input  logic          RST,
  uart_tx_fsm_if.slave  tx_if
);

  tx_state_e state_q, state_d;
  logic      tx_out_q, tx_out_d;
  logic      busy_q, busy_d;
  logic      par_en_q, par_en_d;
  logic      ser_load, ser_shift;
  logic      ser_data, ser_done;

  uart_tx_serializer u_serializer (
    .CLK       (CLK),
    .RST       (RST),
    .load      (ser_load),
    .shift_en  (ser_shift),
    .load_data (tx_if.P_DATA),
    .ser_data  (ser_data),
    .ser_done  (ser_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      par_en_q <= par_en_d;
    end
  end

  // Next-state and next-output logic; outputs are registered so the line
  // value for a cycle is decided on the edge that starts it.
  always_comb begin
    state_d   = state_q;
    tx_out_d  = tx_out_q;
    busy_d    = busy_q;
    par_en_d  = par_en_q;
    ser_load  = 1'b0;
    ser_shift = 1'b0;

    case (state_q)
      IDLE: begin
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
        if (tx_if.Data_Valid) begin
          ser_load = 1'b1;
          par_en_d = tx_if.PAR_EN;
          state_d  = START;
          tx_out_d = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        ser_shift = 1'b1;
        tx_out_d  = ser_data;
        state_d   = DATA;
      end
      DATA: begin
        if (ser_done) begin
          if (par_en_q) begin
            state_d  = PARITY;
            tx_out_d = tx_if.par_bit;
          end else begin
            state_d  = STOP;
            tx_out_d = 1'b1;
          end
        end else begin
          ser_shift = 1'b1;
          tx_out_d  = ser_data;
        end
      end
      PARITY: begin
        state_d  = STOP;
        tx_out_d = 1'b1;
      end
      STOP: begin
        // Leaving STOP lands in IDLE, so a request seen on this edge waits one more cycle.
        state_d  = IDLE;
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        tx_out_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign tx_if.TX_OUT = tx_out_q;
  assign tx_if.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb/tb_uart_tx_fsm.sv - self-checking bench for uart_tx_fsm with a frame-queue reference model
module tb_uart_tx_fsm;
  import uart_tx_fsm_pkg::*;

  logic CLK;
  logic RST;
  logic PAR_TYP;
  int   vectors;
  int   miscompares;
  logic chk_en;

  uart_tx_fsm_if ifc ();

  uart_tx_fsm dut (
    .CLK   (CLK),
    .RST   (RST),
    .tx_if (ifc.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Stand-in for parity_calc: registers the parity of the word on the accepting edge.
  always @(posedge CLK) begin
    if (ifc.Data_Valid && !ifc.Busy)
      ifc.par_bit <= (^ifc.P_DATA) ^ PAR_TYP;
  end

  // Reference model: each accepted word becomes a queue of line values, one per cycle.
  logic exp_q[$];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      exp_q.delete();
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end else if (ifc.Data_Valid) begin
      exp_q.push_back(1'b0);
      for (int b = 0; b < DATA_WIDTH; b++) exp_q.push_back(ifc.P_DATA[b]);
      if (ifc.PAR_EN) exp_q.push_back((^ifc.P_DATA) ^ PAR_TYP);
      exp_q.push_back(1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("model_tx_out", 32'(ifc.TX_OUT), 32'(exp_q.size() != 0 ? exp_q[0] : 1'b1));
      check("model_busy", 32'(ifc.Busy), 32'(exp_q.size() != 0));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    ifc.Data_Valid = 1'b0;
    @(negedge CLK);
    while (ifc.Busy && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (ifc.Busy) begin
      miscompares++;
      $display("FAIL idle_wait: Busy got 1 after 40 cycles, expected 0");
    end
  endtask

  // Sends one word and records the line for len+1 cycles from the accept edge.
  task automatic run_frame(input string name, input logic [7:0] d, input logic en,
                           input logic typ, input int len, input logic [11:0] exp_line,
                           input int inj);
    logic [11:0] line;
    int          busy_cnt;
    wait_idle();
    ifc.P_DATA     = d;
    ifc.PAR_EN     = en;
    PAR_TYP        = typ;
    ifc.Data_Valid = 1'b1;
    line           = '0;
    busy_cnt       = 0;
    for (int i = 0; i <= len; i++) begin
      @(negedge CLK);
      line[i]  = ifc.TX_OUT;
      busy_cnt += int'(ifc.Busy);
      if (i == 0) ifc.Data_Valid = 1'b0;
      if (i == inj) begin
        ifc.Data_Valid = 1'b1;
        ifc.P_DATA     = 8'hFF;
        ifc.PAR_EN     = 1'b1;
      end
      if (i == inj + 1) ifc.Data_Valid = 1'b0;
    end
    check({name, "_line"}, 32'(line), 32'(exp_line));
    check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(len));
  endtask

  task automatic reset_pulse();
    #2 RST = 1'b0;
    #1;
    check("async_reset_tx_out", 32'(ifc.TX_OUT), 32'd1);
    check("async_reset_busy", 32'(ifc.Busy), 32'd0);
    @(negedge CLK);
    #2 RST = 1'b1;
  endtask

  logic [10:0] pat_3c;

  initial begin
    vectors        = 0;
    miscompares    = 0;
    chk_en         = 1'b0;
    RST            = 1'b1;
    PAR_TYP        = 1'b0;
    ifc.P_DATA     = '0;
    ifc.Data_Valid = 1'b0;
    ifc.PAR_EN     = 1'b0;
    ifc.par_bit    = 1'b0;
    #1 RST = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_tx_out", 32'(ifc.TX_OUT), 32'd1);
    check("reset_busy", 32'(ifc.Busy), 32'd0);
    #2 RST = 1'b1;

    // Line bit i is the value seen i cycles after the accept edge; the top bit is the idle cycle after stop.
    run_frame("a1_even", 8'hA1, 1'b1, 1'b0, 11, 12'b1111_0100_0010, -1);
    run_frame("b2_odd",  8'hB2, 1'b1, 1'b1, 11, 12'b1111_0110_0100, -1);
    run_frame("00_nopar", 8'h00, 1'b0, 1'b0, 10, 12'b0110_0000_0000, -1);
    run_frame("55_ignore", 8'h55, 1'b0, 1'b0, 10, 12'b0110_1010_1010, 3);

    // Reset in the middle of the data bits, then the line must stay idle.
    wait_idle();
    ifc.P_DATA = 8'hA5; ifc.PAR_EN = 1'b1; ifc.Data_Valid = 1'b1;
    @(negedge CLK);
    ifc.Data_Valid = 1'b0;
    repeat (4) @(negedge CLK);
    reset_pulse();
    repeat (3) @(negedge CLK);
    check("post_reset_idle_tx", 32'(ifc.TX_OUT), 32'd1);
    check("post_reset_idle_busy", 32'(ifc.Busy), 32'd0);

    // Data_Valid held high: frame every 11 cycles with one idle-high gap.
    pat_3c = 11'b110_0111_1000;
    wait_idle();
    ifc.P_DATA = 8'h3C; ifc.PAR_EN = 1'b0; ifc.Data_Valid = 1'b1;
    for (int k = 0; k < 33; k++) begin
      @(negedge CLK);
      check("held_tx_out", 32'(ifc.TX_OUT), 32'(pat_3c[k % 11]));
      check("held_busy", 32'(ifc.Busy), 32'((k % 11) != 10));
    end
    ifc.Data_Valid = 1'b0;

    // Random traffic: requests, mid-frame input churn and occasional async resets.
    for (int c = 0; c < 700; c++) begin
      @(negedge CLK);
      ifc.Data_Valid = ($urandom_range(0, 2) != 0);
      ifc.P_DATA     = 8'($urandom);
      ifc.PAR_EN     = 1'($urandom);
      PAR_TYP        = 1'($urandom);
      if ($urandom_range(0, 99) == 0) reset_pulse();
    end

    wait_idle();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
